// File: rtl/ps2_panel_switch_ctrl.sv
// PS/2 key events -> Altair front-panel switch positions.
// A cursor (sel_idx) picks one switch. UP, DOWN and SPACE actuate the selected switch.
// LEFT, RIGHT and HOME move the cursor.
// Toggle switches latch their position.
// Momentary switches are driven by a single-active IDLE/ACTIVE/RELEASING machine.
// A momentary switch stays actuated for at least HOLD_CYCLES cycles after the press.
// It falls back to neutral once the key is released and the hold time has elapsed.
module ps2_panel_switch_ctrl #(
    parameter int          NUM_SWITCHES   = 25,
    parameter logic [31:0] MOMENTARY_MASK = 32'h01FE0000,
    parameter int          HOLD_CYCLES    = 2500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [10:0]               ps2_key,
    output logic [2*NUM_SWITCHES-1:0] sw_state,
    output logic [4:0]                sel_idx,
    output logic                      key_event
);

    localparam int            TW     = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_V = TW'(HOLD_CYCLES);
    localparam logic [4:0]    LAST   = 5'(NUM_SWITCHES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RELEASING} state_t;

    state_t                    r_state, w_nxt_state;
    logic [TW-1:0]             r_timer, w_nxt_timer;
    logic                      r_held, w_nxt_held;
    logic                      r_dir_down, w_nxt_dir_down;
    logic                      r_armed, r_prev_toggle;
    logic [2*NUM_SWITCHES-1:0] r_sw, w_nxt_sw;
    logic [4:0]                r_sel, w_nxt_sel;
    logic                      r_key_event;

    logic       w_event, w_pressed, w_ext;
    logic [7:0] w_code;
    logic       w_left, w_right, w_up, w_down, w_home, w_space;
    logic       w_decoded, w_cursor, w_momentary;
    logic [5:0] w_fld;

    // Key decode: an event is a change of the toggle bit once armed.
    always_comb begin
        w_pressed   = ps2_key[9];
        w_ext       = ps2_key[8];
        w_code      = ps2_key[7:0];
        w_event     = r_armed && (ps2_key[10] != r_prev_toggle);
        w_left      = w_ext  && (w_code == 8'h6B);
        w_right     = w_ext  && (w_code == 8'h74);
        w_up        = w_ext  && (w_code == 8'h75);
        w_down      = w_ext  && (w_code == 8'h72);
        w_home      = w_ext  && (w_code == 8'h6C);
        w_space     = !w_ext && (w_code == 8'h29);
        w_decoded   = w_event && (w_left || w_right || w_up || w_down || w_home || w_space);
        w_cursor    = w_decoded && w_pressed && (w_left || w_right || w_home);
        w_momentary = MOMENTARY_MASK[r_sel];
        w_fld       = {r_sel, 1'b0};
    end

    // Next-state: hold-timer progress first, then the decoded event overrides it.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_timer    = (r_timer != '0) ? r_timer - TW'(1) : '0;
        w_nxt_held     = r_held;
        w_nxt_dir_down = r_dir_down;
        w_nxt_sw       = r_sw;
        w_nxt_sel      = r_sel;

        // Released momentary switch whose minimum hold has elapsed returns to neutral.
        if (r_state == S_RELEASING && r_timer <= TW'(1)) begin
            w_nxt_sw[w_fld +: 2] = 2'b00;
            w_nxt_state          = S_IDLE;
            w_nxt_timer          = '0;
        end

        if (w_cursor) begin
            // Leaving an actuated momentary switch forces it back to neutral.
            if (r_state != S_IDLE) begin
                w_nxt_sw[w_fld +: 2] = 2'b00;
                w_nxt_state          = S_IDLE;
                w_nxt_timer          = '0;
                w_nxt_held           = 1'b0;
            end
            if (w_home)
                w_nxt_sel = 5'd0;
            else if (w_left)
                w_nxt_sel = (r_sel == 5'd0) ? LAST : r_sel - 5'd1;
            else
                w_nxt_sel = (r_sel == LAST) ? 5'd0 : r_sel + 5'd1;
        end else if (w_decoded && w_pressed && (w_up || w_down)) begin
            if (!w_momentary) begin
                w_nxt_sw[w_fld +: 2] = w_up ? 2'b01 : 2'b00;
            end else if (r_state != S_ACTIVE || r_dir_down != w_down) begin
                w_nxt_sw[w_fld +: 2] = w_down ? 2'b10 : 2'b01;
                w_nxt_state          = S_ACTIVE;
                w_nxt_timer          = HOLD_V;
                w_nxt_held           = 1'b1;
                w_nxt_dir_down       = w_down;
            end
        end else if (w_decoded && w_pressed && w_space) begin
            if (!w_momentary)
                w_nxt_sw[w_fld] = ~r_sw[w_fld];
        end else if (w_decoded && !w_pressed && (w_up || w_down)) begin
            if (w_momentary && r_state == S_ACTIVE && r_held && r_dir_down == w_down) begin
                w_nxt_held  = 1'b0;
                w_nxt_state = S_RELEASING;
            end
        end
    end

    // State registers; every field clears immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_held        <= 1'b0;
            r_dir_down    <= 1'b0;
            r_armed       <= 1'b0;
            r_prev_toggle <= 1'b0;
            r_sw          <= '0;
            r_sel         <= 5'd0;
            r_key_event   <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_timer       <= w_nxt_timer;
            r_held        <= w_nxt_held;
            r_dir_down    <= w_nxt_dir_down;
            r_armed       <= 1'b1;
            r_prev_toggle <= ps2_key[10];
            r_sw          <= w_nxt_sw;
            r_sel         <= w_nxt_sel;
            r_key_event   <= w_decoded;
        end
    end

    assign sw_state  = r_sw;
    assign sel_idx   = r_sel;
    assign key_event = r_key_event;

endmodule

// File: doc/ps2_panel_switch_ctrl.md
Name: ps2_panel_switch_ctrl

Overview:
- Converts MiSTer PS/2 key events into Altair front-panel switch positions, driving the switch-status bus consumed by the panel renderer and the switch-to-machine mapping.
- A cursor selects one of NUM_SWITCHES switches; arrow and space keys move the cursor or actuate the selected switch.
- Toggle switches latch their position. Momentary switches spring back to neutral after a minimum hold time.
- Sits between hps_io (ps2_key) and the front-panel blocks, in the CLK_VIDEO domain.

Parameters:
- NUM_SWITCHES, 25, number of panel switches (max 32).
- MOMENTARY_MASK, 25'h1FE0000, bit i = 1 means switch i is momentary (spring-return).
- HOLD_CYCLES, 2500000, minimum cycles a momentary switch stays actuated (50 ms at 50 MHz). Must be ≥ 1.

Ports:
- clk  in  1  block clock
- reset  in  1  asynchronous, active-low reset
- ps2_key  in  11  [10] event toggle, [9] pressed(1)/released(0), [8] extended (E0), [7:0] set-2 scancode
- sw_state  out  2*NUM_SWITCHES  switch i at [2i+1:2i]: 00 neutral/down-latched, 01 up, 10 down-momentary
- sel_idx  out  5  currently selected switch, for panel highlight
- key_event  out  1  one-cycle pulse per accepted (decoded) key event

Behaviour:
- Reset (reset low, async):
  - sw_state = 0, sel_idx = 0, key_event = 0.
  - Hold timer = 0, held flag = 0, armed = 0, prev_toggle = 0.
- Arming:
  - armed sets on the first clk edge after reset deasserts. prev_toggle tracks ps2_key[10] every cycle.
  - Event = armed && (ps2_key[10] != prev_toggle), decoded in that same cycle. Events while unarmed are dropped. This avoids a spurious event out of reset.
- Decoded keys (all others ignored, key_event stays 0). key_event pulses the cycle after decode.
  - LEFT, ext=1, 6B
  - RIGHT, ext=1, 74
  - UP, ext=1, 75
  - DOWN, ext=1, 72
  - HOME, ext=1, 6C
  - SPACE, ext=0, 29
- Cursor, on press only:
  - LEFT: sel_idx-1, wrapping 0 -> NUM_SWITCHES-1.
  - RIGHT: sel_idx+1, wrapping NUM_SWITCHES-1 -> 0.
  - HOME: sel_idx = 0.
  - If a momentary switch is active when the cursor moves, it is forced to 00 in the same cycle; timer and held are cleared.
- Toggle switch (mask bit 0), press events:
  - UP -> 01.
  - DOWN -> 00.
  - SPACE -> invert bit 0.
  - Releases have no effect.
- Momentary switch (mask bit 1), single-active state machine with states IDLE, ACTIVE, RELEASING:
  - IDLE, UP press: field = 01, timer = HOLD_CYCLES, held = 1, go to ACTIVE.
  - IDLE, DOWN press: field = 10, same timer/held setup, go to ACTIVE.
  - ACTIVE: timer decrements to 0 and saturates.
    - Release of the same direction key: held = 0, go to RELEASING.
    - Press of the opposite direction: switches the field, reloads the timer, held stays 1.
  - RELEASING: once timer == 0, field = 00 and go to IDLE. If already 0 on release, field returns to 00 the next cycle.
  - SPACE on a momentary switch is ignored.
- Only one switch changes per event. All other fields hold.
- Simultaneous event and timer expiry: the event is processed first. A fresh UP/DOWN press reloads the timer and wins over expiry.
- Width rules:
  - Timer width = $clog2(HOLD_CYCLES+1).
  - sel_idx comparisons use NUM_SWITCHES-1 as the wrap bound. sel_idx never exceeds it.
- Mid-operation reset: all fields return to 00 immediately, including an actuated momentary switch.

Test Plan:
- Reset with ps2_key[10] = 1, release reset -> no key_event; sw_state = 0, sel_idx = 0.
- Toggle ps2_key with {p=1, e=1, 6B} at sel_idx 0 -> sel_idx = 24, key_event pulses once. RIGHT press -> sel_idx = 0.
- sel_idx 3: UP press -> sw_state[7:6] = 01. SPACE press -> 00. SPACE again -> 01. UP release -> still 01.
- HOLD_CYCLES = 10, sel_idx 17:
  - UP press then release after 2 cycles -> [35:34] = 01 for exactly 10 cycles after the press, then 00.
  - Hold UP for 50 cycles -> [35:34] stays 01 until the cycle after release.
- sel_idx 20, DOWN press -> [41:40] = 10. RIGHT press before release -> [41:40] = 00 and sel_idx = 21 in the same update.
- Unmapped key {e=0, 1C} and non-extended 75 -> no key_event, sw_state and sel_idx unchanged. Assert reset low while a momentary switch is active -> all outputs 0 asynchronously.
